// File: rtl/core_pkg.sv
// Shared definitions for the core's pipeline sequencing logic.
//   hz_state_t : fetch-side sequencing states (RUN / FILL / FILL_REDIR)
//   FWD_*      : EX-stage forwarding select encodings
//   RES_MEM    : resultsrc encoding of a load in EX
//   fwd_sel    : forwarding select for one EX source register
package core_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    FILL       = 2'b01,
    FILL_REDIR = 2'b10
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] RES_MEM = 3'b001;

  // MEM has priority over WB; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       regwrite_m,
    input logic [4:0] rd_w,
    input logic       regwrite_w
  );
    if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs))
      return FWD_MEM;
    else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline/icache and the hazard controller.
//   master : pipeline side (drives register ids, enables, cache status;
//            receives stall/flush/forward controls and counters)
//   slave  : hazard controller
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1D, rs2D;
  logic [4:0]       rs1E, rs2E, rdE;
  logic [4:0]       rdM, rdW;
  logic             regwriteM, regwriteW;
  logic [2:0]       resultsrcE;
  logic             pcsrcE;
  logic             icache_miss;
  logic             icache_fill_done;
  logic             stallF, stallD;
  logic             flushD, flushE;
  logic [1:0]       forwardAE, forwardBE;
  logic             icache_fill_start;
  logic             busy;
  logic [CNT_W-1:0] stall_cycles, miss_count;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    output regwriteM, regwriteW, resultsrcE, pcsrcE,
    output icache_miss, icache_fill_done,
    input  stallF, stallD, flushD, flushE, forwardAE, forwardBE,
    input  icache_fill_start, busy, stall_cycles, miss_count
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    input  regwriteM, regwriteW, resultsrcE, pcsrcE,
    input  icache_miss, icache_fill_done,
    output stallF, stallD, flushD, flushE, forwardAE, forwardBE,
    output icache_fill_start, busy, stall_cycles, miss_count
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   clr   : synchronous clear (wins over inc)
//   inc   : count enable
//   count : current value, holds at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clr)
      count_reg <= '0;
    else if (inc && (count_reg != {W{1'b1}}))
      count_reg <= count_reg + {{(W-1){1'b0}}, 1'b1};
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: IF/ID and ID/EX stall/flush, EX-stage
// forwarding selects, icache miss-fill sequencing and perf counters.
//   clk, rst : clock, synchronous active-high reset
//   hz       : hazard_ctrl_if.slave bundle (register ids, write enables,
//              resultsrcE, pcsrcE, icache status in; stall/flush/forward
//              controls, fill start, busy, counters out)
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int         CNT_W   = 32,
  parameter logic [2:0] RES_MEM = core_pkg::RES_MEM
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  hz_state_t  state_reg, state_next;
  logic       stall_f, stall_d, flush_d, flush_e, fill_start;
  logic       lwstall, front_hold;

  // Forwarding, one select per EX source register.
  logic [4:0] rs_e [2];
  logic [1:0] fwd  [2];

  assign rs_e[0] = hz.rs1E;
  assign rs_e[1] = hz.rs2E;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd[gi] = fwd_sel(rs_e[gi], hz.rdM, hz.regwriteM,
                               hz.rdW, hz.regwriteW);
    end
  endgenerate

  assign hz.forwardAE = rst ? FWD_RF : fwd[0];
  assign hz.forwardBE = rst ? FWD_RF : fwd[1];

  assign lwstall = (hz.resultsrcE == RES_MEM) && (hz.rdE != 5'd0) &&
                   ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

  // Fetch cannot proceed: a fill is outstanding, or RUN just missed.
  assign front_hold = (state_reg != RUN) || hz.icache_miss;

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= RUN;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    fill_start = 1'b0;

    if (rst) begin
      state_next = RUN;
      flush_d    = 1'b1;
      flush_e    = 1'b1;
    end else if (hz.pcsrcE) begin
      // Redirect: everything younger than EX is wrong-path, so a
      // concurrent miss or load-use is dropped. An outstanding fill
      // must still complete, but its line is no longer wanted.
      flush_d = 1'b1;
      flush_e = 1'b1;
      case (state_reg)
        FILL:       state_next = hz.icache_fill_done ? RUN : FILL_REDIR;
        FILL_REDIR: state_next = hz.icache_fill_done ? RUN : FILL_REDIR;
        default:    state_next = RUN;
      endcase
    end else if (front_hold) begin
      stall_f = 1'b1;
      if (lwstall) begin
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        // ID drains into EX while a bubble enters ID.
        flush_d = 1'b1;
      end
      case (state_reg)
        RUN: begin
          // Only reachable here with icache_miss=1.
          fill_start = 1'b1;
          state_next = FILL;
        end
        FILL, FILL_REDIR: begin
          if (hz.icache_fill_done)
            state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end else if (lwstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign hz.stallF            = stall_f;
  assign hz.stallD            = stall_d;
  assign hz.flushD            = flush_d;
  assign hz.flushE            = flush_e;
  assign hz.icache_fill_start = fill_start;
  assign hz.busy              = !rst && (state_reg != RUN);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall_f),
    .count (hz.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (fill_start),
    .count (hz.miss_count)
  );

endmodule
